// File: rtl/tmp_pkg.sv
// rtl/tmp_pkg.sv - shared types and defaults for the temperature pump decoder
package tmp_pkg;

  // Decoder sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_PUBLISH = 2'd2
  } tmp_state_e;

  localparam int CNT_W_DEF   = 12;
  localparam int EVT_W_DEF   = 10;
  localparam int MAX_WIN_DEF = 4095;
  localparam int WIN_W       = 12;

  // Signed temperature code as seen by the register block
  typedef logic signed [CNT_W_DEF-1:0] tmp_code_t;

endpackage

// File: rtl/tmp_pump_decoder_if.sv
// rtl/tmp_pump_decoder_if.sv - result handshake bus between decoder and readout
interface tmp_pump_decoder_if
  import tmp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EVT_W = EVT_W_DEF
);

  logic signed [CNT_W-1:0] code;
  logic [EVT_W-1:0]        n_snk;
  logic [EVT_W-1:0]        n_src;
  logic                    code_valid;
  logic                    code_ready;
  logic                    ovf;
  logic                    timeout;
  logic                    overrun;

  modport master (
    output code, n_snk, n_src, code_valid, ovf, timeout, overrun,
    input  code_ready
  );

  modport slave (
    input  code, n_snk, n_src, code_valid, ovf, timeout, overrun,
    output code_ready
  );

endinterface

// File: rtl/tmp_sat_counter.sv
// rtl/tmp_sat_counter.sv - up/down saturating counter with clip flag
module tmp_sat_counter #(
  parameter int W      = 12,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         clip
);

  // Limits held two bits wider than the count so the raw sum never wraps
  localparam logic signed [W+1:0] MAX_V = SIGNED ? {3'b000, {(W-1){1'b1}}}
                                                 : {2'b00, {W{1'b1}}};
  localparam logic signed [W+1:0] MIN_V = SIGNED ? {3'b111, {(W-1){1'b0}}}
                                                 : {(W+2){1'b0}};

  logic signed [W+1:0] cur_ext;
  logic signed [W+1:0] sum;
  logic [W-1:0]        nxt;

  // Extend, add the step, then clamp to the representable range
  always_comb begin
    cur_ext = SIGNED ? {{2{value[W-1]}}, value} : {2'b00, value};
    sum     = cur_ext + {{(W+1){1'b0}}, inc} - {{(W+1){1'b0}}, dec};
    nxt     = sum[W-1:0];
    clip    = 1'b0;
    if (sum > MAX_V) begin
      nxt  = MAX_V[W-1:0];
      clip = en;
    end else if (sum < MIN_V) begin
      nxt  = MIN_V[W-1:0];
      clip = en;
    end
  end

  // Count register; clear wins over a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (en) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/tmp_pump_decoder.sv
// rtl/tmp_pump_decoder.sv - integrates sink/source pump toggles into a signed temperature code
module tmp_pump_decoder
  import tmp_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int EVT_W   = EVT_W_DEF,
  parameter int MAX_WIN = MAX_WIN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            snk_tgl,
  input  logic            src_tgl,
  input  logic            frame,
  input  logic            setup_bias,
  tmp_pump_decoder_if.master res
);

  tmp_state_e       state, state_d;
  logic             snk_q, src_q, frame_q;
  logic             snk_evt, src_evt;
  logic             start, accum_en, tmo_d;
  logic [WIN_W-1:0] win;
  logic             ovf_acc, tmo_flag;
  logic [CNT_W-1:0] acc;
  logic [EVT_W-1:0] cnt_snk, cnt_src;
  logic             clip_acc, clip_snk, clip_src;

  assign snk_evt  = snk_tgl ^ snk_q;
  assign src_evt  = src_tgl ^ src_q;
  assign accum_en = (state == ST_ACCUM);

  // Previous-value registers for edge detection, updated in every state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snk_q   <= 1'b0;
      src_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      snk_q   <= snk_tgl;
      src_q   <= src_tgl;
      frame_q <= frame;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Next state: bias setup aborts first, then frame fall, then window expiry
  always_comb begin
    state_d = state;
    start   = 1'b0;
    tmo_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame && !frame_q && !setup_bias) begin
          state_d = ST_ACCUM;
          start   = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (setup_bias) begin
          state_d = ST_IDLE;
        end else if (!frame && frame_q) begin
          state_d = ST_PUBLISH;
        end else if (win == WIN_W'(MAX_WIN)) begin
          state_d = ST_PUBLISH;
          tmo_d   = 1'b1;
        end
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Window counter and sticky per-frame flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win      <= '0;
      ovf_acc  <= 1'b0;
      tmo_flag <= 1'b0;
    end else if (start) begin
      win      <= '0;
      ovf_acc  <= 1'b0;
      tmo_flag <= 1'b0;
    end else if (accum_en) begin
      win      <= win + 1'b1;
      ovf_acc  <= ovf_acc | clip_acc | clip_snk | clip_src;
      tmo_flag <= tmo_d;
    end
  end

  tmp_sat_counter #(.W(CNT_W), .SIGNED(1'b1)) u_acc (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start),
    .en    (accum_en),
    .inc   (snk_evt),
    .dec   (src_evt),
    .value (acc),
    .clip  (clip_acc)
  );

  tmp_sat_counter #(.W(EVT_W), .SIGNED(1'b0)) u_cnt_snk (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start),
    .en    (accum_en),
    .inc   (snk_evt),
    .dec   (1'b0),
    .value (cnt_snk),
    .clip  (clip_snk)
  );

  tmp_sat_counter #(.W(EVT_W), .SIGNED(1'b0)) u_cnt_src (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (start),
    .en    (accum_en),
    .inc   (src_evt),
    .dec   (1'b0),
    .value (cnt_src),
    .clip  (clip_src)
  );

  // Result registers and valid/ready handshake; a publish overrides acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res.code       <= '0;
      res.n_snk      <= '0;
      res.n_src      <= '0;
      res.ovf        <= 1'b0;
      res.timeout    <= 1'b0;
      res.code_valid <= 1'b0;
      res.overrun    <= 1'b0;
    end else if (state == ST_PUBLISH) begin
      if (res.code_valid && !res.code_ready) res.overrun <= 1'b1;
      res.code       <= acc;
      res.n_snk      <= cnt_snk;
      res.n_src      <= cnt_src;
      res.ovf        <= ovf_acc;
      res.timeout    <= tmo_flag;
      res.code_valid <= 1'b1;
    end else if (res.code_valid && res.code_ready) begin
      res.code_valid <= 1'b0;
    end
  end

endmodule

// File: doc/tmp_pump_decoder.md
Name: tmp_pump_decoder

Overview:
- Receiving end of the temperature-sensor pump interface.
- The sensor controller toggles its sink/source charge-pump control lines once per pump decision. This block detects each toggle, integrates sink-minus-source events over a measurement frame, and publishes a signed temperature code on a valid/ready handshake to the readout/register block.
- Sits in the digital top, same clock domain as the controller.

Parameters:
- CNT_W, 12, width of the signed net accumulator and of `code`.
- EVT_W, 10, width of each unsigned per-frame event counter.
- MAX_WIN, 4095, frame timeout in clk cycles; the window counter is 12 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- snk_tgl  input  1  sink-pump control level; each transition is one sink event.
- src_tgl  input  1  source-pump control level; each transition is one source event.
- frame  input  1  high while the controller is in its measurement sequence.
- setup_bias  input  1  high during bias setup; aborts and suppresses conversion.
- code  output  CNT_W  signed net count, snk minus src, of the last completed frame.
- n_snk  output  EVT_W  sink events in the last frame.
- n_src  output  EVT_W  source events in the last frame.
- code_valid  output  1  result available.
- code_ready  input  1  consumer accepts the result.
- ovf  output  1  saturation occurred in the published frame.
- timeout  output  1  published frame ended by MAX_WIN, not by frame fall.
- overrun  output  1  sticky; an unaccepted result was overwritten.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - all outputs 0, state IDLE, accumulators 0.
  - snk_q/src_q (previous-value registers) are 0.
- Edge detect:
  - snk_q and src_q are updated every cycle in every state.
  - snk_evt = snk_tgl ^ snk_q; src_evt = src_tgl ^ src_q.
  - An event counts in the cycle the toggle is first seen, i.e. one cycle of latency.
  - Events are counted only in ACCUM, so toggles in IDLE, and any stale level after reset, never count.
- FSM states:
  - IDLE:
    - frame_q tracks frame.
    - On frame rising (frame & ~frame_q) with setup_bias=0 -> ACCUM.
    - On entry to ACCUM: acc=0, cnt_snk=0, cnt_src=0, win=0, ovf_acc=0.
  - ACCUM, each cycle:
    - win += 1.
    - acc += snk_evt - src_evt. Simultaneous events give a net change of 0, but both counters increment.
    - acc saturates at +(2^(CNT_W-1)-1) and -(2^(CNT_W-1)); any clipped update sets ovf_acc.
    - Event counters saturate at 2^EVT_W-1; saturation also sets ovf_acc.
    - Events seen in the same cycle as the terminating condition are included.
  - ACCUM exits:
    - setup_bias=1 -> IDLE. Frame discarded, nothing published. This takes priority over everything else.
    - frame falls -> PUBLISH.
    - win == MAX_WIN -> PUBLISH with timeout flag set.
  - PUBLISH (one cycle):
    - If code_valid=1 and code_ready=0, set overrun.
    - Load code, n_snk, n_src, ovf, timeout; set code_valid=1.
    - -> IDLE.
- Handshake:
  - code_valid stays high and all result outputs stay stable until a cycle with code_valid & code_ready; code_valid clears the next cycle.
  - code_ready is ignored while code_valid=0.
  - If PUBLISH coincides with code_valid & code_ready, the old result counts as accepted, no overrun is flagged, and code_valid stays 1 with the new data.
- overrun is cleared only by reset.
- Back-to-back frames: after PUBLISH, a frame rise is detected in the following IDLE cycle, so minimum frame spacing is 1 idle cycle. A rise occurring in the PUBLISH cycle is lost.
- Reset mid-ACCUM: everything clears immediately and no partial result is published.

Decomposition:
- Shared package tmp_pkg:
  - typedef enum for the state (IDLE, ACCUM, PUBLISH);
  - default constants for CNT_W, EVT_W, MAX_WIN;
  - the signed-code typedef, also used by the register block.
- One natural sub-module: tmp_sat_counter, an up/down saturating counter with a clip flag. It is instantiated once signed for acc and twice unsigned for the event counters.

Test Plan:
- 20 snk toggles and 7 src toggles inside one frame, spaced 3 cycles apart, code_ready=1 -> code=13, n_snk=20, n_src=7, code_valid pulses for 1 cycle, ovf=0, timeout=0.
- snk and src toggle in the same cycle 5 times, with no other events -> code=0, n_snk=5, n_src=5.
- setup_bias asserted mid-frame after 9 events, then frame falls -> no code_valid, outputs keep their previous values.
- frame held high for more than MAX_WIN cycles with 3 snk toggles -> PUBLISH at win=4095, code=3, timeout=1.
- Two frames with code_ready=0 (codes 4 then -2) -> code=-2, overrun=1 and stays set. Raising code_ready clears code_valid the next cycle.
- With CNT_W=4, 9 snk toggles and 0 src -> code=7, ovf=1. Assert reset_n=0 mid-frame -> all outputs 0 in the same cycle.
